// File: rtl/icache_axi_master_pkg.sv
// ---------------------------------------------------------------------------
// icache_axi_master_pkg
// Shared definitions for the L1 instruction-cache AXI master:
//   - cache access-type encodings carried on I_type
//   - AXI4 burst/size/response constants
//   - master FSM state enumeration
//   - response decode helper
// No ports (package).
// ---------------------------------------------------------------------------
package icache_axi_master_pkg;

    // Cache access types
    localparam logic [2:0] CACHE_BYTE    = 3'b000;
    localparam logic [2:0] CACHE_HWORD   = 3'b001;
    localparam logic [2:0] CACHE_WORD    = 3'b010;
    localparam logic [2:0] CACHE_BYTE_U  = 3'b100;
    localparam logic [2:0] CACHE_HWORD_U = 3'b101;

    // AXI constants
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_BYTE   = 3'd0;
    localparam logic [2:0] SIZE_HALF   = 3'd1;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WRESP,
        ST_DONE
    } state_t;

    // SLVERR and DECERR both report as an error to the cache.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/icache_axi_master_if.sv
// ---------------------------------------------------------------------------
// icache_axi_master_if
// Single-beat AXI4 master port (AR/R/AW/W/B channels).
// Modports:
//   master - drives AR*/AW*/W* payload + valids, RREADY, BREADY
//   slave  - drives ARREADY, R*, AWREADY, WREADY, B*
// ---------------------------------------------------------------------------
interface icache_axi_master_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Read address
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [3:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;
    // Read data
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;
    // Write address
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    // Write data
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    // Write response
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/icache_axi_master_wstrb_gen.sv
// ---------------------------------------------------------------------------
// axi_wstrb_gen
// Combinational lane steering for one cache access.
//   access_type in  3   cache access type (CACHE_*)
//   addr_lo     in  2   byte address bits [1:0]
//   data_in     in  32  LSB-aligned write data
//   wstrb       out 4   byte-lane strobes
//   wdata       out 32  write data shifted onto its byte lanes
//   size        out 3   AXI transfer size (AR/AWSIZE)
// ---------------------------------------------------------------------------
module axi_wstrb_gen
    import icache_axi_master_pkg::*;
(
    input  logic [2:0]  access_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data_in,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [2:0]  size
);

    always_comb begin
        wstrb = 4'b1111;
        wdata = data_in;
        size  = SIZE_WORD;
        case (access_type)
            CACHE_BYTE, CACHE_BYTE_U: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = data_in << {addr_lo, 3'b000};
                size  = SIZE_BYTE;
            end
            // Halfwords ignore addr[0]: the access is forced onto a half lane pair.
            CACHE_HWORD, CACHE_HWORD_U: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = data_in << {addr_lo[1], 4'b0000};
                size  = SIZE_HALF;
            end
            CACHE_WORD: ;
            default: ;  // unused encodings fall back to a full word
        endcase
    end

endmodule

// File: rtl/icache_axi_master.sv
// ---------------------------------------------------------------------------
// icache_axi_master
// Converts each L1 I-cache memory request into one single-beat AXI4
// transaction and reports completion back to the cache.
//   clk, rstn             clock, async active-low reset
//   I_req/I_addr/I_write  request, byte address, 1=write
//   I_in/I_type           LSB-aligned write data, access type
//   I_out/I_wait/I_err    read data, busy (0 = done/idle), error pulse
//   m0                    AXI4 master port
// ---------------------------------------------------------------------------
module icache_axi_master
    import icache_axi_master_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter logic [ID_W-1:0] MASTER_ID = '0,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic              I_write,
    input  logic [DATA_W-1:0] I_in,
    input  logic [2:0]        I_type,
    output logic [DATA_W-1:0] I_out,
    output logic              I_wait,
    output logic              I_err,
    icache_axi_master_if.master m0
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] in_q;
    logic [2:0]        type_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              aw_done, w_done;
    logic              aw_ok, w_ok;
    logic [3:0]        strb;
    logic [DATA_W-1:0] wdata_sh;
    logic [2:0]        size;
    logic              unused_axi;

    axi_wstrb_gen u_wstrb_gen (
        .access_type (type_q),
        .addr_lo     (addr_q[1:0]),
        .data_in     (in_q),
        .wstrb       (strb),
        .wdata       (wdata_sh),
        .size        (size)
    );

    // Channel complete either earlier (flag) or in this cycle.
    assign aw_ok = aw_done || m0.AWREADY;
    assign w_ok  = w_done  || m0.WREADY;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        I_wait     = 1'b1;
        m0.ARVALID = 1'b0;
        m0.RREADY  = 1'b0;
        m0.AWVALID = 1'b0;
        m0.WVALID  = 1'b0;
        m0.BREADY  = 1'b0;
        case (state)
            ST_IDLE: begin
                I_wait = I_req;
                if (I_req) state_nxt = I_write ? ST_WADDR : ST_RADDR;
            end
            ST_RADDR: begin
                m0.ARVALID = 1'b1;
                if (m0.ARREADY) state_nxt = ST_RDATA;
            end
            ST_RDATA: begin
                m0.RREADY = 1'b1;
                if (m0.RVALID) state_nxt = ST_DONE;
            end
            ST_WADDR: begin
                m0.AWVALID = !aw_done;
                m0.WVALID  = !w_done;
                if (aw_ok && w_ok) state_nxt = ST_WRESP;
            end
            ST_WRESP: begin
                m0.BREADY = 1'b1;
                if (m0.BVALID) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                I_wait    = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request payload: only captured in IDLE, so it stays stable for the
    // whole transaction regardless of what the cache does meanwhile.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && I_req) begin
            addr_q <= I_addr;
            in_q   <= I_in;
            type_q <= I_type;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q  <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                ST_RDATA: if (m0.RVALID) begin
                    data_q <= m0.RDATA;
                    err_q  <= resp_is_err(m0.RRESP);
                end
                ST_WADDR: begin
                    if (aw_ok && w_ok) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_ok;
                        w_done  <= w_ok;
                    end
                end
                ST_WRESP: if (m0.BVALID) err_q <= resp_is_err(m0.BRESP);
                default: ;
            endcase
        end
    end

    assign I_out = data_q;
    assign I_err = (state == ST_DONE) && err_q;

    assign m0.ARID    = MASTER_ID;
    assign m0.ARADDR  = addr_q;
    assign m0.ARLEN   = 4'd0;
    assign m0.ARSIZE  = size;
    assign m0.ARBURST = BURST_INCR;
    assign m0.AWID    = MASTER_ID;
    assign m0.AWADDR  = addr_q;
    assign m0.AWLEN   = 4'd0;
    assign m0.AWSIZE  = size;
    assign m0.AWBURST = BURST_INCR;
    assign m0.WDATA   = wdata_sh;
    assign m0.WSTRB   = strb;
    assign m0.WLAST   = 1'b1;

    // IDs and RLAST are not checked for single-beat, single-ID traffic.
    assign unused_axi = ^{m0.RID, m0.RLAST, m0.BID};

endmodule

// File: tb/tb_icache_axi_master.sv
module tb_icache_axi_master;
    import icache_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        I_req;
    logic [31:0] I_addr;
    logic        I_write;
    logic [31:0] I_in;
    logic [2:0]  I_type;
    logic [31:0] I_out;
    logic        I_wait;
    logic        I_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd;

    icache_axi_master_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m0 ();

    icache_axi_master #(
        .ID_W(4), .MASTER_ID(4'd5), .ADDR_W(32), .DATA_W(32)
    ) dut (
        .clk(clk), .rstn(rstn),
        .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_in(I_in), .I_type(I_type),
        .I_out(I_out), .I_wait(I_wait), .I_err(I_err),
        .m0(m0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] din;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic        hold;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [2:0]  e_size;
        logic        e_err;
        logic [31:0] e_out;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slave_idle();
        m0.ARREADY = 1'b0;  m0.AWREADY = 1'b0; m0.WREADY = 1'b0;
        m0.RVALID  = 1'b0;  m0.BVALID  = 1'b0;
        m0.RID = 4'd5; m0.BID = 4'd5; m0.RLAST = 1'b1;
        m0.RDATA = $urandom; m0.RRESP = 2'($urandom_range(0, 3));
        m0.BRESP = 2'($urandom_range(0, 3));
    endtask

    // Garbage on the request inputs while busy; it must be ignored.
    task automatic scramble(input logic hold);
        I_req   = hold ? 1'b1 : 1'($urandom_range(0, 1));
        I_addr  = $urandom;
        I_in    = $urandom;
        I_write = 1'($urandom_range(0, 1));
        I_type  = 3'($urandom_range(0, 7));
    endtask

    // Reference: which bytes an access touches and where the data lands.
    function automatic int nbytes_of(input logic [2:0] t);
        if (t == CACHE_BYTE || t == CACHE_BYTE_U)   return 1;
        if (t == CACHE_HWORD || t == CACHE_HWORD_U) return 2;
        return 4;
    endfunction

    task automatic model_access(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                                output logic [3:0] strb, output logic [31:0] wdata,
                                output logic [2:0] size);
        int n   = nbytes_of(t);
        int off = (int'(a[1:0]) / n) * n;
        for (int i = 0; i < 4; i++) strb[i] = (i >= off) && (i < off + n);
        wdata = d << (8 * off);
        size  = (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
    endtask

    task automatic run_txn(input vec_t v);
        // request cycle (IDLE)
        @(negedge clk);
        slave_idle();
        I_req = 1'b1; I_addr = v.addr; I_write = v.wr; I_in = v.din; I_type = v.typ;
        #1;
        chk("req_wait", 32'(I_wait), 1);
        chk("req_arvalid", 32'(m0.ARVALID), 0);
        if (!v.wr) begin
            for (int j = 0; j <= v.ar_d; j++) begin
                @(negedge clk);
                slave_idle(); scramble(v.hold);
                m0.ARREADY = (j == v.ar_d);
                #1;
                chk("arvalid", 32'(m0.ARVALID), 1);
                chk("araddr", m0.ARADDR, v.addr);
                chk("arsize", 32'(m0.ARSIZE), 32'(v.e_size));
                chk("arlen", 32'(m0.ARLEN), 0);
                chk("arburst", 32'(m0.ARBURST), 1);
                chk("arid", 32'(m0.ARID), 5);
                chk("rready_early", 32'(m0.RREADY), 0);
                chk("wait_raddr", 32'(I_wait), 1);
                chk("err_raddr", 32'(I_err), 0);
            end
            for (int j = 0; j <= v.r_d; j++) begin
                @(negedge clk);
                slave_idle(); scramble(v.hold);
                if (j == v.r_d) begin
                    m0.RVALID = 1'b1; m0.RDATA = v.rdata; m0.RRESP = v.resp;
                end
                #1;
                chk("rready", 32'(m0.RREADY), 1);
                chk("arvalid_rdata", 32'(m0.ARVALID), 0);
                chk("wait_rdata", 32'(I_wait), 1);
                chk("err_rdata", 32'(I_err), 0);
            end
        end else begin
            int n = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
            for (int j = 0; j <= n; j++) begin
                @(negedge clk);
                slave_idle(); scramble(v.hold);
                m0.AWREADY = (j == v.aw_d);
                m0.WREADY  = (j == v.w_d);
                #1;
                chk("awvalid", 32'(m0.AWVALID), 32'(j <= v.aw_d));
                chk("wvalid", 32'(m0.WVALID), 32'(j <= v.w_d));
                if (j <= v.aw_d) begin
                    chk("awaddr", m0.AWADDR, v.addr);
                    chk("awsize", 32'(m0.AWSIZE), 32'(v.e_size));
                    chk("awlen", 32'(m0.AWLEN), 0);
                    chk("awburst", 32'(m0.AWBURST), 1);
                    chk("awid", 32'(m0.AWID), 5);
                end
                if (j <= v.w_d) begin
                    chk("wdata", m0.WDATA, v.e_wdata);
                    chk("wstrb", 32'(m0.WSTRB), 32'(v.e_strb));
                    chk("wlast", 32'(m0.WLAST), 1);
                end
                chk("bready_early", 32'(m0.BREADY), 0);
                chk("wait_waddr", 32'(I_wait), 1);
            end
            for (int j = 0; j <= v.b_d; j++) begin
                @(negedge clk);
                slave_idle(); scramble(v.hold);
                if (j == v.b_d) begin
                    m0.BVALID = 1'b1; m0.BRESP = v.resp;
                end
                #1;
                chk("bready", 32'(m0.BREADY), 1);
                chk("awvalid_wresp", 32'(m0.AWVALID), 0);
                chk("wvalid_wresp", 32'(m0.WVALID), 0);
                chk("wait_wresp", 32'(I_wait), 1);
                chk("err_wresp", 32'(I_err), 0);
            end
        end
        // completion cycle
        @(negedge clk);
        slave_idle(); scramble(v.hold);
        I_req = v.hold;
        #1;
        chk("done_wait", 32'(I_wait), 0);
        chk("done_out", I_out, v.e_out);
        chk("done_err", 32'(I_err), 32'(v.e_err));
        chk("done_arvalid", 32'(m0.ARVALID), 0);
        chk("done_awvalid", 32'(m0.AWVALID), 0);
        chk("done_rready", 32'(m0.RREADY), 0);
        chk("done_bready", 32'(m0.BREADY), 0);
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] typ,
                                input logic [31:0] din, input logic [31:0] rdata,
                                input logic [1:0] resp, input int ar_d, input int r_d,
                                input int aw_d, input int w_d, input int b_d, input logic hold,
                                input logic [3:0] e_strb, input logic [31:0] e_wdata,
                                input logic [2:0] e_size, input logic e_err,
                                input logic [31:0] e_out);
        vec_t v;
        v.wr = wr; v.addr = addr; v.typ = typ; v.din = din; v.rdata = rdata; v.resp = resp;
        v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.hold = hold;
        v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_size = e_size; v.e_err = e_err;
        v.e_out = e_out;
        return v;
    endfunction

    initial begin
        // Directed vectors with hand-computed expectations.
        vecs[0]  = mk(0, 32'h0000_1004, CACHE_WORD, 0, 32'hDEAD_BEEF, RESP_OKAY, 0, 0, 0, 0, 0, 0,
                      4'h0, 0, 3'd2, 0, 32'hDEAD_BEEF);
        vecs[1]  = mk(0, 32'h0000_1008, CACHE_WORD, 0, 32'h1234_5678, RESP_OKAY, 3, 2, 0, 0, 0, 0,
                      4'h0, 0, 3'd2, 0, 32'h1234_5678);
        vecs[2]  = mk(1, 32'h0000_2001, CACHE_BYTE, 32'h0000_00A5, 0, RESP_OKAY, 0, 0, 0, 0, 0, 0,
                      4'b0010, 32'h0000_A500, 3'd0, 0, 32'h1234_5678);
        vecs[3]  = mk(1, 32'h0000_2002, CACHE_HWORD, 32'h0000_1234, 0, RESP_OKAY, 0, 0, 0, 0, 0, 0,
                      4'b1100, 32'h1234_0000, 3'd1, 0, 32'h1234_5678);
        vecs[4]  = mk(1, 32'h0000_2004, CACHE_WORD, 32'hCAFE_F00D, 0, RESP_OKAY, 0, 0, 2, 0, 1, 0,
                      4'b1111, 32'hCAFE_F00D, 3'd2, 0, 32'h1234_5678);
        vecs[5]  = mk(0, 32'h0000_0100, CACHE_WORD, 0, 32'hA000_0100, RESP_OKAY, 0, 0, 0, 0, 0, 1,
                      4'h0, 0, 3'd2, 0, 32'hA000_0100);
        vecs[6]  = mk(0, 32'h0000_0104, CACHE_WORD, 0, 32'hA000_0104, RESP_OKAY, 0, 0, 0, 0, 0, 1,
                      4'h0, 0, 3'd2, 0, 32'hA000_0104);
        vecs[7]  = mk(0, 32'h0000_0108, CACHE_WORD, 0, 32'hA000_0108, RESP_OKAY, 0, 0, 0, 0, 0, 1,
                      4'h0, 0, 3'd2, 0, 32'hA000_0108);
        vecs[8]  = mk(0, 32'h0000_010C, CACHE_WORD, 0, 32'hA000_010C, RESP_OKAY, 0, 0, 0, 0, 0, 0,
                      4'h0, 0, 3'd2, 0, 32'hA000_010C);
        vecs[9]  = mk(0, 32'h0000_0300, CACHE_WORD, 0, 32'hBADB_AD00, RESP_SLVERR, 0, 1, 0, 0, 0, 0,
                      4'h0, 0, 3'd2, 1, 32'hBADB_AD00);
        vecs[10] = mk(1, 32'h0000_3003, CACHE_BYTE, 32'h0000_005A, 0, RESP_DECERR, 0, 0, 1, 1, 0, 0,
                      4'b1000, 32'h5A00_0000, 3'd0, 1, 32'hBADB_AD00);
        vecs[11] = mk(0, 32'h0000_0401, CACHE_BYTE_U, 0, 32'h0000_0077, RESP_OKAY, 1, 0, 0, 0, 0, 0,
                      4'h0, 0, 3'd0, 0, 32'h0000_0077);
        vecs[12] = mk(0, 32'h0000_0402, CACHE_HWORD_U, 0, 32'h0000_BEEF, RESP_OKAY, 0, 0, 0, 0, 0, 0,
                      4'h0, 0, 3'd1, 0, 32'h0000_BEEF);
        vecs[13] = mk(1, 32'h0000_2003, CACHE_HWORD, 32'hFFFF_5678, 0, RESP_OKAY, 0, 0, 0, 2, 0, 0,
                      4'b1100, 32'h5678_0000, 3'd1, 0, 32'h0000_BEEF);

        // Reset state
        rstn = 1'b0; I_req = 1'b0; I_addr = 0; I_write = 0; I_in = 0; I_type = CACHE_WORD;
        slave_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wait", 32'(I_wait), 0);
        chk("rst_out", I_out, 0);
        chk("rst_err", 32'(I_err), 0);
        chk("rst_valids", {28'd0, m0.ARVALID, m0.AWVALID, m0.WVALID, 1'b0}, 0);
        chk("rst_readys", {30'd0, m0.RREADY, m0.BREADY}, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("idle_wait", 32'(I_wait), 0);

        for (int i = 0; i < 14; i++) run_txn(vecs[i]);

        // Reset in the middle of a read (RDATA phase).
        @(negedge clk);
        slave_idle();
        I_req = 1'b1; I_write = 1'b0; I_addr = 32'h500; I_type = CACHE_WORD;
        @(negedge clk);
        I_req = 1'b0; m0.ARREADY = 1'b1;
        #1;
        chk("mid_arvalid", 32'(m0.ARVALID), 1);
        @(negedge clk);
        m0.ARREADY = 1'b0;
        #1;
        chk("mid_rready", 32'(m0.RREADY), 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rready", 32'(m0.RREADY), 0);
        chk("mid_rst_arvalid", 32'(m0.ARVALID), 0);
        chk("mid_rst_out", I_out, 0);
        chk("mid_rst_err", 32'(I_err), 0);
        chk("mid_rst_wait0", 32'(I_wait), 0);
        I_req = 1'b1;
        #1;
        chk("mid_rst_wait1", 32'(I_wait), 1);
        @(negedge clk);
        I_req = 1'b0;
        rstn = 1'b1;
        #1;
        chk("post_rst_wait", 32'(I_wait), 0);
        chk("post_rst_rready", 32'(m0.RREADY), 0);
        last_rd = 32'h0;
        run_txn(mk(1, 32'h0000_0600, CACHE_WORD, 32'h0BAD_CAFE, 0, RESP_OKAY, 0, 0, 0, 0, 0, 0,
                   4'b1111, 32'h0BAD_CAFE, 3'd2, 0, 32'h0));

        // Randomized traffic checked against the reference model.
        for (int k = 0; k < 40; k++) begin
            vec_t v;
            logic [2:0] types[5] = '{CACHE_BYTE, CACHE_HWORD, CACHE_WORD, CACHE_BYTE_U, CACHE_HWORD_U};
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.typ   = types[$urandom_range(0, 4)];
            v.din   = $urandom;
            v.rdata = $urandom;
            v.resp  = 2'($urandom_range(0, 3));
            v.ar_d  = $urandom_range(0, 3);
            v.r_d   = $urandom_range(0, 3);
            v.aw_d  = $urandom_range(0, 3);
            v.w_d   = $urandom_range(0, 3);
            v.b_d   = $urandom_range(0, 3);
            v.hold  = (k == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            model_access(v.typ, v.addr, v.din, v.e_strb, v.e_wdata, v.e_size);
            v.e_err = (v.resp == RESP_SLVERR) || (v.resp == RESP_DECERR);
            if (!v.wr) last_rd = v.rdata;
            v.e_out = last_rd;
            run_txn(v);
        end

        @(negedge clk);
        I_req = 1'b0;
        #1;
        chk("final_idle_wait", 32'(I_wait), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
